// File: rtl/data_memory_be_pkg.sv
// Shared encodings and lane helpers for the byte-enabled data memory.
// Size codes, FSM states, byte-enable mask and load extraction.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << lane;
            SZ_H:    m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = {{24{sign & b[7]}}, b};
            SZ_H:    r = {{16{sign & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Request/response bundle between the MEM stage and the data memory.
interface data_memory_be_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] wdata;
    logic        ready;
    logic        busy;
    logic        rvalid;
    logic [31:0] rdata;
    logic        align_err;

    modport master (
        output req, we, addr, size, sign, wdata,
        input  ready, busy, rvalid, rdata, align_err
    );

    modport slave (
        input  req, we, addr, size, sign, wdata,
        output ready, busy, rvalid, rdata, align_err
    );
endinterface

// File: rtl/data_memory_be_byte_ram.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
// The array itself is never reset; the top-level sweep clears it.
module dm_byte_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/data_memory_be.sv
// MEM-stage data memory: clear sweep after reset, byte/half/word stores,
// sign/zero-extended loads with 1-cycle latency, misalignment detection.
module data_memory_be
    import dm_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter bit CLR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    data_memory_be_if.slave  bus
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr;

    logic [1:0]        lane;
    logic [ADDR_W-1:0] widx;
    logic              acc, bad, st_ok, ld_ok;

    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata, ram_q, steer;

    logic              ld_pend, err_q, ld_sign;
    logic [1:0]        ld_size, ld_lane;
    logic [31:0]       rdata_hold, ld_data;
    logic              unused_addr;

    assign lane  = bus.addr[1:0];
    assign widx  = bus.addr[ADDR_W+1:2];
    assign unused_addr = ^bus.addr[31:ADDR_W+2];

    assign acc   = bus.req & (state == IDLE);
    assign bad   = misaligned(bus.size, lane);
    assign st_ok = acc & bus.we & ~bad;
    assign ld_ok = acc & ~bus.we & ~bad;

    // Replicate store data across lanes; byte enables pick the target lanes.
    always_comb begin
        case (bus.size)
            SZ_B:    steer = {4{bus.wdata[7:0]}};
            SZ_H:    steer = {2{bus.wdata[15:0]}};
            default: steer = bus.wdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (!CLR_EN || clr_ptr == {ADDR_W{1'b1}}) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ram_we    = 4'b0000;
        ram_waddr = widx;
        ram_wdata = steer;
        if (state == CLEAR) begin
            if (CLR_EN) begin
                ram_we    = 4'b1111;
                ram_waddr = clr_ptr;
                ram_wdata = 32'h0;
            end
        end else if (st_ok) begin
            ram_we = be_mask(bus.size, lane);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    dm_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (widx),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_pend    <= 1'b0;
            err_q      <= 1'b0;
            ld_size    <= SZ_W;
            ld_lane    <= 2'b00;
            ld_sign    <= 1'b0;
            rdata_hold <= 32'h0;
        end else begin
            ld_pend <= ld_ok;
            err_q   <= acc & bad;
            if (ld_ok) begin
                ld_size <= bus.size;
                ld_lane <= lane;
                ld_sign <= bus.sign;
            end
            if (ld_pend) rdata_hold <= ld_data;
        end
    end

    // The RAM read is already registered, so extraction is combinational on
    // its output; the hold register keeps rdata stable between loads.
    assign ld_data       = ld_extract(ram_q, ld_size, ld_lane, ld_sign);
    assign bus.rdata     = ld_pend ? ld_data : rdata_hold;
    assign bus.rvalid    = ld_pend;
    assign bus.align_err = err_q;
    assign bus.ready     = (state == IDLE);
    assign bus.busy      = (state == CLEAR);
endmodule
